// File: rtl/writeback_stage_pkg.sv
// Shared core definitions for the writeback stage: load funct3 encodings,
// load-queue entry layout and the per-cycle writeback source selector.
package writeback_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Raw load response; formatting is deferred until the entry is dequeued.
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] rdata;
    logic [1:0]      addr_lo;
    logic [2:0]      funct3;
  } lq_entry_t;

  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_ALU  = 2'd1,
    SEL_POP  = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/wb_load_queue.sv
// FIFO of pending load responses with occupancy count and a per-entry
// destination-register match vector used for WAW hazard detection.
module wb_load_queue
  import writeback_stage_pkg::*;
#(
  parameter int LQ_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  lq_entry_t                   push_entry,
  input  logic                        pop,
  input  logic [4:0]                  query_rd,
  output lq_entry_t                   head,
  output logic [$clog2(LQ_DEPTH):0]   count,
  output logic                        full,
  output logic                        empty,
  output logic [LQ_DEPTH-1:0]         match_vec
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;

  lq_entry_t             mem [LQ_DEPTH];
  logic [LQ_DEPTH-1:0]   valid;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (pop) begin
        rd_ptr        <= rd_ptr + PW'(1);
        valid[rd_ptr] <= 1'b0;
      end
      // Push after pop so a simultaneous push/pop at full keeps the slot valid.
      if (push) begin
        wr_ptr        <= wr_ptr + PW'(1);
        valid[wr_ptr] <= 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      match_vec[i] = valid[i] && (mem[i].rd == query_rd);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(LQ_DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/writeback_stage.sv
// Writeback arbitration between the ALU path and queued load responses,
// with load formatting at dequeue and a registered register-file write port.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LQ_DEPTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_valid_i,
  input  logic [4:0]                    alu_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]         alu_data_i,
  output logic                          alu_stall_o,
  input  logic                          mem_valid_i,
  output logic                          mem_ready_o,
  input  logic [4:0]                    mem_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
  input  logic [1:0]                    mem_addr_lo_i,
  input  logic [2:0]                    mem_funct3_i,
  output logic                          reg_write_o,
  output logic [4:0]                    rd_addr_o,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic [$clog2(LQ_DEPTH):0]     lq_count_o
);

  function automatic logic [DATA_WIDTH-1:0] format_load(
    input logic [2:0]            f3,
    input logic [1:0]            lo,
    input logic [DATA_WIDTH-1:0] word
  );
    logic [DATA_WIDTH-1:0] shifted;
    logic signed [7:0]     byte_s;
    logic signed [15:0]    half_s;
    logic [DATA_WIDTH-1:0] res;
    shifted = word >> {lo, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   res = DATA_WIDTH'(byte_s);
      F3_LH:   res = DATA_WIDTH'(half_s);
      F3_LBU:  res = DATA_WIDTH'($unsigned(byte_s));
      F3_LHU:  res = DATA_WIDTH'($unsigned(half_s));
      default: res = word;
    endcase
    return res;
  endfunction

  lq_entry_t               push_entry;
  lq_entry_t               head;
  logic                    lq_full;
  logic                    lq_empty;
  logic [LQ_DEPTH-1:0]     match_vec;
  logic                    waw_hit;
  logic                    pop;
  logic                    push;
  wb_sel_e                 sel_p0;
  logic [4:0]              wb_rd_p0;
  logic [DATA_WIDTH-1:0]   wb_data_p0;
  logic                    vld_p1;
  logic [4:0]              rd_p1;
  logic [DATA_WIDTH-1:0]   data_p1;

  assign push_entry.rd      = mem_rd_addr_i;
  assign push_entry.rdata   = mem_rdata_i;
  assign push_entry.addr_lo = mem_addr_lo_i;
  assign push_entry.funct3  = mem_funct3_i;

  wb_load_queue #(
    .LQ_DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .query_rd   (alu_rd_addr_i),
    .head       (head),
    .count      (lq_count_o),
    .full       (lq_full),
    .empty      (lq_empty),
    .match_vec  (match_vec)
  );

  // An ALU write to a register still pending in the queue must wait for the
  // older load to retire first.
  assign waw_hit = alu_valid_i && (alu_rd_addr_i != 5'd0) && (|match_vec);

  always_comb begin
    sel_p0 = SEL_IDLE;
    if (lq_full || waw_hit) begin
      sel_p0 = SEL_POP;
    end else if (alu_valid_i) begin
      sel_p0 = SEL_ALU;
    end else if (!lq_empty) begin
      sel_p0 = SEL_POP;
    end
  end

  assign pop         = (sel_p0 == SEL_POP);
  assign mem_ready_o = !lq_full || pop;
  assign push        = mem_valid_i && mem_ready_o;
  assign alu_stall_o = alu_valid_i && (lq_full || waw_hit);

  always_comb begin
    wb_rd_p0   = alu_rd_addr_i;
    wb_data_p0 = alu_data_i;
    if (pop) begin
      wb_rd_p0   = head.rd;
      wb_data_p0 = format_load(head.funct3, head.addr_lo, head.rdata);
    end
  end

  // ---- p0 -> p1: register-file write port ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= (sel_p0 != SEL_IDLE) && (wb_rd_p0 != 5'd0);
      if (sel_p0 != SEL_IDLE) begin
        rd_p1   <= wb_rd_p0;
        data_p1 <= wb_data_p0;
      end
    end
  end

  assign reg_write_o = vld_p1;
  assign rd_addr_o   = rd_p1;
  assign rd_data_o   = data_p1;

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width (only 32 supported).
REQ-002 SHALL have parameter LQ_DEPTH, default 2, load-result queue entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port alu_valid_i  input  1  ALU-path result present.
REQ-006 SHALL have port alu_rd_addr_i  input  5  ALU destination register.
REQ-007 SHALL have port alu_data_i  input  DATA_WIDTH  ALU result.
REQ-008 SHALL have port alu_stall_o  output  1  ALU result not taken this cycle; hold inputs.
REQ-009 SHALL have port mem_valid_i  input  1  load response present.
REQ-010 SHALL have port mem_ready_o  output  1  load response accepted when high with mem_valid_i.
REQ-011 SHALL have port mem_rd_addr_i  input  5  load destination register.
REQ-012 SHALL have port mem_rdata_i  input  DATA_WIDTH  raw aligned memory word.
REQ-013 SHALL have port mem_addr_lo_i  input  2  byte offset of load address.
REQ-014 SHALL have port mem_funct3_i  input  3  load type.
REQ-015 SHALL have ports reg_write_o  output  1, rd_addr_o  output  5, rd_data_o  output  DATA_WIDTH  register-file write port.
REQ-016 SHALL have port lq_count_o  output  $clog2(LQ_DEPTH)+1  queue occupancy.

Function
REQ-017 Load handshake: transfer when mem_valid_i && mem_ready_o; entry stores rd, raw word, addr_lo, funct3 (formatting at dequeue).
REQ-018 mem_ready_o SHALL be high when queue not full, or full and a pop occurs this cycle (simultaneous push/pop at full allowed).
REQ-019 Arbitration per cycle, priority order: (a) queue full -> pop head; (b) alu_valid_i and alu_rd_addr_i nonzero and equal to rd of any queued entry -> pop head (WAW drain); (c) alu_valid_i -> take ALU; (d) queue non-empty -> pop head; (e) idle.
REQ-020 alu_stall_o SHALL be combinational, high exactly when alu_valid_i and case (a) or (b) selected.
REQ-021 Write port SHALL be registered: selection in cycle N appears on reg_write_o/rd_addr_o/rd_data_o in cycle N+1, for exactly one cycle.
REQ-022 Selected item with rd 0 SHALL be consumed but reg_write_o SHALL stay 0.
REQ-023 Load formatting, byte b=addr_lo, half h=addr_lo[1]: 000 LB sign-extend byte b; 001 LH sign-extend half h; 010 LW full word; 100 LBU zero-extend byte b; 101 LHU zero-extend half h; other funct3 full word.
REQ-024 Queue SHALL be FIFO, pointers wrap modulo LQ_DEPTH; pop from empty or push to full never occurs.
REQ-025 Push to empty queue SHALL not be eligible for pop in the same cycle (earliest write: 2 cycles after acceptance).
REQ-026 lq_count_o SHALL equal occupancy after the current edge, +1/-1/0 for push/pop/both.

Reset
REQ-027 On rst_n low: queue empty, lq_count_o 0, reg_write_o 0, rd_addr_o 0, rd_data_o 0, immediately (async).
REQ-028 Mid-operation reset SHALL discard all queued and in-flight results; no write after deassertion until new input.
REQ-029 During reset mem_ready_o SHALL be 1 and alu_stall_o follows REQ-020 with an empty queue.

Structure
REQ-030 Load funct3 encodings and the queue-entry struct SHALL live in the shared core package.
REQ-031 Queue SHALL be a sub-module wb_load_queue (storage, pointers, count, rd-match vector); format and arbitration in writeback_stage.

Verification
REQ-032 ALU only: alu_valid_i=1, rd=5, data=0x1234_5678 -> next cycle reg_write_o=1, rd_addr_o=5, rd_data_o=0x1234_5678; alu_stall_o=0.
REQ-033 LB/LBU/LH/LHU: rdata=0x80FF_7F01 -> LB off1 0x0000_007F; LB off2 0xFFFF_FFFF; LBU off3 0x0000_0080; LH off2 0xFFFF_80FF; LHU off0 0x0000_7F01.
REQ-034 WAW: load rd=7 queued, ALU rd=7 same cycle -> alu_stall_o=1, load written first, ALU rd=7 next cycle.
REQ-035 Full queue: two loads queued while ALU streams rd=1..4 -> third load accepted only with a pop, alu_stall_o=1 on pop cycles, lq_count_o never exceeds 2.
REQ-036 rd=0: ALU rd=0 data=0xDEAD_BEEF -> no reg_write_o pulse; reset with 2 queued -> lq_count_o=0, no writes afterwards.
